sr_drive_sequencer: RTL and testbench

Drive-side controller for a bank of WIDTH clocked SR flip-flops (set/reset/hold, with 11 as the illegal input). It accepts target words over a valid/ready handshake and converts each into one cycle of per-bit set/reset pulses using the SR excitation table. It keeps a shadow copy of the bank contents and, when enabled, reads back the bank outputs to flag mismatches. It sits between control logic and any SR register bank, and guarantees the bank never sees S=R=1.

---
 rtl/sr_drive_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sr_drive_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_sequencer.sv
// Drive-side sequencer for a bank of WIDTH clocked SR flip-flops: turns target words into one-cycle set/reset pulses.
// Optional readback check of the bank outputs is enabled by defining SR_DRV_CHECK_EN.
module sr_drive_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] shadow,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_IDLE   = 3'd4;

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Bits that must go 0->1 get a set pulse; bits that must go 1->0 get a reset pulse.
    function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] target,
                                                  input logic [WIDTH-1:0] current);
        return target & ~current;
    endfunction

    function automatic logic [WIDTH-1:0] clr_mask(input logic [WIDTH-1:0] target,
                                                  input logic [WIDTH-1:0] current);
        return ~target & current;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] word_r;
    logic             init_seq_r;
    logic             accept_s;
    logic [WIDTH-1:0] s_next_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] diff_s;

    assign accept_s = in_valid & in_ready & (state_r == ST_IDLE);

`ifdef SR_DRV_CHECK_EN
    assign diff_s = q_in ^ shadow;
`else
    logic unused_q_s;
    assign unused_q_s = ^q_in;
    assign diff_s     = {WIDTH{1'b0}};
`endif

    // Sequencer next-state: fixed walk INIT->DRIVE->SETTLE->CHECK->IDLE, IDLE leaves only on accept.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT:  state_next_s = ST_DRIVE;
            ST_DRIVE: state_next_s = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_CHECK: state_next_s = ST_IDLE;
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_DRIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default:  state_next_s = ST_INIT;
        endcase
    end

    // Pulse pattern for the upcoming DRIVE cycle; the bank has no reset, so the first DRIVE clears it.
    always_comb begin
        s_next_s = {WIDTH{1'b0}};
        r_next_s = {WIDTH{1'b0}};
        if (state_r == ST_INIT) begin
            r_next_s = {WIDTH{1'b1}};
        end else if (accept_s) begin
            s_next_s = set_mask(in_data, shadow);
            r_next_s = clr_mask(in_data, shadow);
        end else begin
            s_next_s = {WIDTH{1'b0}};
            r_next_s = {WIDTH{1'b0}};
        end
    end

    // State, settle counter and latched target word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            cnt_r      <= CNT_ZERO;
            word_r     <= {WIDTH{1'b0}};
            init_seq_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_SETTLE) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= CNT_ZERO;
            end
            if (accept_s) begin
                word_r <= in_data;
            end else begin
                word_r <= word_r;
            end
            if (state_r == ST_CHECK) begin
                init_seq_r <= 1'b0;
            end else begin
                init_seq_r <= init_seq_r;
            end
        end
    end

    // Bank drive pulses and shadow copy; set is masked by reset so S=R=1 can never leave the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_out  <= {WIDTH{1'b0}};
            r_out  <= {WIDTH{1'b0}};
            shadow <= {WIDTH{1'b0}};
        end else begin
            s_out <= s_next_s & ~r_next_s;
            r_out <= r_next_s;
            if (state_r == ST_DRIVE) begin
                shadow <= word_r;
            end else begin
                shadow <= shadow;
            end
        end
    end

    // Handshake/status outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= {WIDTH{1'b0}};
        end else begin
            in_ready <= (state_next_s == ST_IDLE);
            busy     <= (state_next_s != ST_IDLE);
            done     <= (state_r == ST_CHECK) & ~init_seq_r;
            if (state_r == ST_CHECK) begin
                err      <= |diff_s;
                err_mask <= diff_s;
            end else begin
                err      <= 1'b0;
                err_mask <= {WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Self-checking bench for sr_drive_sequencer: a cycle-timeline model plus directed literal checks.
// A behavioural SR bank (with an optional stuck-at-0 mask) closes the readback loop.
module tb_sr_drive_sequencer;
    localparam int W        = 8;
    localparam int S        = 1;
    localparam int IDLE_REL = 3 + S;
`ifdef SR_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = 8'h00;
    logic         in_ready, busy, done, err;
    logic [W-1:0] s_out, r_out, shadow, err_mask, q_in;
    logic [W-1:0] bank  = 8'h5A;
    logic [W-1:0] stuck = 8'h00;

    int n_cmp = 0, n_fail = 0, n_done = 0, n_acc = 0, cyc = 0, last_acc = 0;

    // Model: position in the current word's timeline (1 = drive cycle), target and prior contents.
    int           rel    = 0;
    logic [W-1:0] m_word = 8'h00, m_prev = 8'h00, m_diff = 8'h00;
    bit           m_init = 1'b1;
    logic [W-1:0] e_s, e_r, e_sh, e_mask;
    logic         e_rdy, e_done, e_err;

    sr_drive_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .s_out(s_out), .r_out(r_out), .q_in(q_in),
        .shadow(shadow), .busy(busy), .done(done), .err(err), .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    assign q_in = bank & ~stuck;

    always @(posedge clk) bank <= (bank & ~r_out) | s_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel    <= 0;
            m_word <= 8'h00;
            m_prev <= 8'h00;
            m_diff <= 8'h00;
            m_init <= 1'b1;
        end else begin
            cyc <= cyc + 1;
            if (rel == 2 + S) m_diff <= q_in ^ m_word;
            if (rel >= IDLE_REL && in_valid) begin
                m_prev   <= m_word;
                m_word   <= in_data;
                m_init   <= 1'b0;
                rel      <= 1;
                n_acc    <= n_acc + 1;
                last_acc <= cyc + 1;
            end else if (rel <= IDLE_REL) begin
                rel <= rel + 1;
            end
        end
    end

    always_comb begin
        e_s = 8'h00;
        e_r = 8'h00;
        if (rel == 1) begin
            if (m_init) begin
                e_r = 8'hFF;
            end else begin
                e_s = m_word & ~m_prev;
                e_r = ~m_word & m_prev;
            end
        end
        e_sh   = (rel >= 2) ? m_word : m_prev;
        e_rdy  = (rel >= IDLE_REL);
        e_done = (rel == IDLE_REL) && !m_init;
        e_err  = CHK && (rel == IDLE_REL) && (m_diff != 8'h00);
        e_mask = (CHK && rel == IDLE_REL) ? m_diff : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("s_out", s_out, e_s);
        check("r_out", r_out, e_r);
        check("sr_excl", s_out & r_out, 8'h00);
        check("shadow", shadow, e_sh);
        check("in_ready", in_ready, e_rdy);
        check("busy", busy, !e_rdy);
        check("done", done, e_done);
        check("err", err, e_err);
        check("err_mask", err_mask, e_mask);
        if (done) n_done <= n_done + 1;
    end

    task automatic send(input logic [7:0] w, input bit keep);
        int start;
        bit got;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_data  = w;
        start    = n_acc;
        got      = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            if (n_acc != start) got = 1'b1;
        end
        check("accept_timeout", got, 1);
        if (!keep) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_data  = ~w;
        end
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] r_hist [2:6];
        logic       rdy_hist [2:6];
        logic       err_hist [2:6];
        int         t1, t2, nd;
        bit         rdy_seen;

        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk); #1;
            r_hist[c]   = r_out;
            rdy_hist[c] = in_ready;
            err_hist[c] = err;
        end
        check("init_r_c2", r_hist[2], 8'hFF);
        check("init_r_c3", r_hist[3], 8'h00);
        check("init_rdy_c4", rdy_hist[4], 1'b0);
        check("init_rdy_c5", rdy_hist[5], 1'b1);
        check("init_err_c5", err_hist[5], 1'b0);
        check("init_no_done", n_done, 0);

        send(8'hA5, 1'b0);
        check("a5_s", s_out, 8'hA5);
        check("a5_r", r_out, 8'h00);
        wait_edges(3);
        check("a5_done", done, 1'b1);
        check("a5_shadow", shadow, 8'hA5);
        check("a5_err", err, 1'b0);

        send(8'h3C, 1'b0);
        check("3c_s", s_out, 8'h18);
        check("3c_r", r_out, 8'h81);
        wait_edges(3);
        check("3c_done", done, 1'b1);
        check("3c_shadow", shadow, 8'h3C);

        stuck = 8'h04;
        send(8'h04, 1'b0);
        wait_edges(3);
        check("stuck_done", done, 1'b1);
        check("stuck_err", err, CHK ? 1'b1 : 1'b0);
        check("stuck_mask", err_mask, CHK ? 8'h04 : 8'h00);
        stuck = 8'h00;

        send(8'h01, 1'b1);
        t1 = last_acc;
        check("b2b_w1_s", s_out, 8'h01);
        check("b2b_w1_r", r_out, 8'h04);
        send(8'h01, 1'b1);
        t2 = last_acc;
        check("b2b_gap12", t2 - t1, 4);
        check("b2b_w2_s", s_out, 8'h00);
        check("b2b_w2_r", r_out, 8'h00);
        wait_edges(3);
        check("b2b_w2_done", done, 1'b1);
        send(8'hFF, 1'b0);
        check("b2b_gap23", last_acc - t2, 4);
        check("b2b_w3_s", s_out, 8'hFE);
        wait_edges(3);
        check("b2b_w3_shadow", shadow, 8'hFF);

        send(8'h0F, 1'b0);
        check("rst_pre_r", r_out, 8'hF0);
        #1;
        nd    = n_done;
        rst_n = 1'b0;
        #1;
        check("rst_async_s", s_out, 8'h00);
        check("rst_async_r", r_out, 8'h00);
        check("rst_busy", busy, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n    = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 20 && !rdy_seen; i++) begin
            @(negedge clk); #1;
            if (in_ready) rdy_seen = 1'b1;
        end
        check("rst_ready_timeout", rdy_seen, 1'b1);
        check("rst_no_done", n_done, nd);
        check("rst_shadow", shadow, 8'h00);

        send(8'h5A, 1'b0);
        check("post_s", s_out, 8'h5A);
        wait_edges(3);
        check("post_done", done, 1'b1);
        check("post_shadow", shadow, 8'h5A);
        wait_edges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
